rd_result_uart: RTL

- Downstream consumer of the SDRAM read-test stage.
- Each completed read is reported by a one-cycle ack with the read data and its address. This block queues those results in a small FIFO.
- Each result is formatted as an ASCII hex line and transmitted on a UART TX pin (8N1). This gives a host terminal a log of address/data pairs for board bring-up.

---
 rtl/rd_result_uart.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rd_result_uart.sv
// rd_result_uart: queues SDRAM read results and logs each one as an ASCII hex
// line "AAAAAAA:DDDD\r\n" on an 8N1 UART TX pin.
// Build macro RD_UART_SEQ_EN: prefix each line with the 2-digit hex line count
// taken at LOAD time, followed by a space.

module rd_result_uart #(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iACK,
    input  logic [DATA_W-1:0] iDATA,
    input  logic [ADDR_W-1:0] iADDR,
    output logic              oTXD,
    output logic              oBUSY,
    output logic              oOVERFLOW,
    output logic [7:0]        oLINES
);

    localparam int unsigned DIV         = CLK_HZ / BAUD;
    localparam int unsigned CNT_W       = $clog2(DIV);
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTF_W      = PTR_W + 1;
    localparam int unsigned ENTRY_W     = ADDR_W + DATA_W;
    localparam int unsigned ADDR_DIGITS = (ADDR_W + 3) / 4;
    localparam int unsigned DATA_DIGITS = (DATA_W + 3) / 4;
    localparam int unsigned ADDR_PW     = ADDR_DIGITS * 4;
    localparam int unsigned DATA_PW     = DATA_DIGITS * 4;
`ifdef RD_UART_SEQ_EN
    localparam int unsigned PRE_N       = 3;
`else
    localparam int unsigned PRE_N       = 0;
`endif
    localparam int unsigned NUM_CHARS   = PRE_N + ADDR_DIGITS + 1 + DATA_DIGITS + 2;
    localparam int unsigned CIDX_W      = $clog2(NUM_CHARS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHAR,
        S_START,
        S_BITS,
        S_STOP
    } state_t;

    state_t              state;
    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNTF_W-1:0]   count;
    logic [CNTF_W-1:0]   count_nx_c;
    logic                push_c;
    logic                pop_c;
    logic                full_c;
    logic [CNT_W-1:0]    baud_cnt;
    logic                baud_done_c;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;
    logic [CIDX_W-1:0]   char_idx;
    logic                last_char_c;
    logic                line_done_c;
    logic                busy_nx_c;
    logic [ADDR_W-1:0]   line_addr;
    logic [DATA_W-1:0]   line_data;
    logic [ADDR_PW-1:0]  addr_pad_c;
    logic [DATA_PW-1:0]  data_pad_c;
    int                  char_pos_c;
    int unsigned         nib_sh_c;
    logic [3:0]          nib_c;
    logic [7:0]          char_c;
`ifdef RD_UART_SEQ_EN
    logic [7:0]          seq_tag;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
    endfunction

    // FIFO push/pop decisions; a pop frees a slot for a same-cycle push
    always_comb begin
        pop_c      = (state == S_LOAD);
        full_c     = (count == CNTF_W'(FIFO_DEPTH));
        push_c     = iACK && (!full_c || pop_c);
        count_nx_c = count;
        if (push_c && !pop_c) begin
            count_nx_c = count + CNTF_W'(1);
        end else if (!push_c && pop_c) begin
            count_nx_c = count - CNTF_W'(1);
        end
    end

    // Bit-timer, end-of-line and look-ahead busy terms
    always_comb begin
        baud_done_c = (baud_cnt == CNT_W'(DIV - 1));
        last_char_c = (char_idx == CIDX_W'(NUM_CHARS - 1));
        line_done_c = (state == S_STOP) && baud_done_c && last_char_c;
        busy_nx_c   = (count_nx_c != '0) ||
                      !(((state == S_IDLE) && (count == '0)) || line_done_c);
    end

    // Character generator for the current line position
    always_comb begin
        addr_pad_c = ADDR_PW'(line_addr);
        data_pad_c = DATA_PW'(line_data);
        char_pos_c = int'(char_idx) - int'(PRE_N);
        nib_sh_c   = 0;
        nib_c      = 4'h0;
        char_c     = 8'h0A;
        if (char_pos_c < 0) begin
`ifdef RD_UART_SEQ_EN
            if (char_pos_c == -3) begin
                char_c = hex_char(seq_tag[7:4]);
            end else if (char_pos_c == -2) begin
                char_c = hex_char(seq_tag[3:0]);
            end else begin
                char_c = 8'h20;
            end
`else
            char_c = 8'h20;
`endif
        end else if (char_pos_c < int'(ADDR_DIGITS)) begin
            nib_sh_c = 4 * (ADDR_DIGITS - 1 - unsigned'(char_pos_c));
            nib_c    = 4'(addr_pad_c >> nib_sh_c);
            char_c   = hex_char(nib_c);
        end else if (char_pos_c == int'(ADDR_DIGITS)) begin
            char_c = 8'h3A;
        end else if (char_pos_c < int'(ADDR_DIGITS + 1 + DATA_DIGITS)) begin
            nib_sh_c = 4 * (ADDR_DIGITS + DATA_DIGITS - unsigned'(char_pos_c));
            nib_c    = 4'(data_pad_c >> nib_sh_c);
            char_c   = hex_char(nib_c);
        end else if (char_pos_c == int'(ADDR_DIGITS + 1 + DATA_DIGITS)) begin
            char_c = 8'h0D;
        end
    end

    // FIFO storage; contents need no reset, pointers define validity
    always_ff @(posedge iCLK) begin
        if (push_c) begin
            mem[wr_ptr] <= {iADDR, iDATA};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            oOVERFLOW <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nx_c;
            if (iACK && !push_c) begin
                oOVERFLOW <= 1'b1;
            end
        end
    end

    // Line/character/bit sequencer driving the serial pin
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state     <= S_IDLE;
            oTXD      <= 1'b1;
            oBUSY     <= 1'b0;
            oLINES    <= 8'd0;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'd0;
            char_idx  <= '0;
            line_addr <= '0;
            line_data <= '0;
`ifdef RD_UART_SEQ_EN
            seq_tag   <= 8'd0;
`endif
        end else begin
            oBUSY <= busy_nx_c;
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    {line_addr, line_data} <= mem[rd_ptr];
`ifdef RD_UART_SEQ_EN
                    seq_tag <= oLINES;
`endif
                    char_idx <= '0;
                    state    <= S_CHAR;
                end
                S_CHAR: begin
                    shift    <= char_c;
                    oTXD     <= 1'b0;
                    baud_cnt <= '0;
                    state    <= S_START;
                end
                S_START: begin
                    if (baud_done_c) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        oTXD     <= shift[0];
                        state    <= S_BITS;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_BITS: begin
                    if (baud_done_c) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            oTXD  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            oTXD    <= shift[1];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_done_c) begin
                        baud_cnt <= '0;
                        if (last_char_c) begin
                            oLINES <= oLINES + 8'd1;
                            state  <= S_IDLE;
                        end else begin
                            char_idx <= char_idx + CIDX_W'(1);
                            state    <= S_CHAR;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
